// File: rtl/rx_dram_wr_arbiter.sv
// Round-robin drain of whole packets from NUM_CH RX FIFOs into one circular DRAM write region.
// Latency: Buffer_Data_Ready rise to first pop 3 edges; pop to DRAM write 2 cycles; 4 idle cycles between packets.
// Backpressure: pops stop in the cycle DRAM_WR_ready drops; up to 2 in-flight words are still written.
module rx_dram_wr_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int PKT_WORDS  = 128,
  parameter int ADDR_WIDTH = 24,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   DRAM_RD_clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      Buffer_Data_Ready,
  input  logic [NUM_CH-1:0]      RX_Buffer_empty,
  input  logic [16*NUM_CH-1:0]   Buffer_RD_Data,
  output logic [NUM_CH-1:0]      DRAM_RD_req,
  input  logic                   DRAM_WR_ready,
  output logic                   DRAM_WR_en,
  output logic [ADDR_WIDTH-1:0]  DRAM_WR_addr,
  output logic [15:0]            DRAM_WR_data,
  output logic [2:0]             Grant_Ch,
  output logic                   Pkt_Done,
  output logic                   Header_Err,
  output logic                   Trailer_Err,
  output logic                   Timeout_Err,
  input  logic                   Err_Clr
);

  localparam int                 STALL_W    = $clog2(TIMEOUT + 1);
  localparam logic [8:0]         PKT_N      = 9'(PKT_WORDS);
  localparam logic [8:0]         PKT_LAST   = 9'(PKT_WORDS - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  localparam logic [2:0]         LAST_CH    = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic [NUM_CH-1:0]     r_sync1;
  logic [NUM_CH-1:0]     r_sync2;
  logic [2:0]            r_last_grant;
  logic [8:0]            r_word_cnt;
  logic [STALL_W-1:0]    r_stall;
  logic                  r_drain;
  logic                  r_pop_d1;
  logic [8:0]            r_idx_d1;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;

  logic [NUM_CH-1:0]     w_ready;
  logic [NUM_CH-1:0]     w_rot;
  logic [2:0]            w_start;
  logic [2:0]            w_off;
  logic [3:0]            w_sum;
  logic [2:0]            w_grant;
  logic                  w_g_empty;
  logic [15:0]           w_q;
  logic                  w_pop;
  logic                  w_hdr_set;
  logic                  w_trl_set;
  logic                  w_to_set;

  // Two-flop synchroniser for the asynchronous packet-ready flags
  always_ff @(posedge DRAM_RD_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= Buffer_Data_Ready;
      r_sync2 <= r_sync1;
    end
  end

  assign w_ready = r_sync2 & ~RX_Buffer_empty;

  // Round-robin pick: rotate so the search starts at last_grant+1, take the lowest set bit, rotate back
  always_comb begin
    w_start = (r_last_grant == LAST_CH) ? 3'd0 : r_last_grant + 3'd1;
    w_rot   = NUM_CH'({w_ready, w_ready} >> w_start);
    w_off   = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
    w_sum   = {1'b0, w_start} + {1'b0, w_off};
    w_grant = (w_sum >= 4'(NUM_CH)) ? 3'(w_sum - 4'(NUM_CH)) : w_sum[2:0];
  end

  // Select empty flag and FIFO q of the granted channel; fan the pop out one-hot
  always_comb begin
    w_g_empty   = 1'b1;
    w_q         = 16'h0000;
    DRAM_RD_req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (Grant_Ch == 3'(i)) begin
        w_g_empty      = RX_Buffer_empty[i];
        w_q            = Buffer_RD_Data[16*i +: 16];
        DRAM_RD_req[i] = w_pop;
      end
    end
  end

  assign w_pop     = (r_state == S_READ) && DRAM_WR_ready && !w_g_empty && (r_word_cnt < PKT_N);
  assign w_hdr_set = r_pop_d1 && (r_idx_d1 == 9'd0) && (w_q != 16'hDEAD);
  assign w_trl_set = r_pop_d1 && (r_idx_d1 == PKT_LAST) && (w_q != 16'hBEEF);
  assign w_to_set  = (r_state == S_READ) && !w_pop && (r_stall == STALL_LAST);

  // Packet FSM: arbitrate, pop a whole packet, let in-flight words land, then pulse done
  always_ff @(posedge DRAM_RD_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= LAST_CH;
      Grant_Ch     <= 3'd0;
      r_word_cnt   <= 9'd0;
      r_stall      <= '0;
      r_drain      <= 1'b0;
      Pkt_Done     <= 1'b0;
    end else begin
      Pkt_Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_ready) begin
            Grant_Ch     <= w_grant;
            r_last_grant <= w_grant;
            r_word_cnt   <= 9'd0;
            r_stall      <= '0;
            r_state      <= S_READ;
          end
        end
        S_READ: begin
          r_drain <= 1'b0;
          if (w_pop) begin
            r_word_cnt <= r_word_cnt + 9'd1;
            r_stall    <= '0;
            if (r_word_cnt == PKT_LAST) r_state <= S_DRAIN;
          end else begin
            r_stall <= r_stall + 1'b1;
            if (w_to_set) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) begin
            r_state  <= S_DONE;
            Pkt_Done <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Write pipeline: pop in t, q valid in t+1 and captured, DRAM write driven in t+2
  always_ff @(posedge DRAM_RD_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_d1     <= 1'b0;
      r_idx_d1     <= 9'd0;
      r_wr_ptr     <= '0;
      DRAM_WR_en   <= 1'b0;
      DRAM_WR_data <= 16'h0000;
      DRAM_WR_addr <= '0;
    end else begin
      r_pop_d1   <= w_pop;
      r_idx_d1   <= r_word_cnt;
      DRAM_WR_en <= r_pop_d1;
      if (r_pop_d1) begin
        DRAM_WR_data <= w_q;
        DRAM_WR_addr <= r_wr_ptr;
        r_wr_ptr     <= r_wr_ptr + 1'b1;
      end
    end
  end

  // Sticky framing/timeout flags; a set in the same cycle as Err_Clr wins
  always_ff @(posedge DRAM_RD_clk or negedge rst_n) begin
    if (!rst_n) begin
      Header_Err  <= 1'b0;
      Trailer_Err <= 1'b0;
      Timeout_Err <= 1'b0;
    end else begin
      Header_Err  <= w_hdr_set | (Header_Err  & ~Err_Clr);
      Trailer_Err <= w_trl_set | (Trailer_Err & ~Err_Clr);
      Timeout_Err <= w_to_set  | (Timeout_Err & ~Err_Clr);
    end
  end

endmodule
